// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: debounced push-button mode sequencer driving the LED latch stage.
// Modes cycle OFF -> LEFT -> RIGHT -> BLINK -> OFF on each debounced press.
// Each pattern change is announced with a single-cycle led_en strobe.
// Optional feature: define LED_FLOW_PAUSE_EN to add a `pause` input that freezes the step timer.
module led_flow_ctrl #(
    parameter int unsigned LED_WIDTH    = 8,
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned STEP_CNT     = 12500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in,
`ifdef LED_FLOW_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 led_en,
    output logic [LED_WIDTH-1:0] led_value
);

    localparam int unsigned DCW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned SCW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    logic                 sync1_q, sync2_q;
    logic                 deb_q, deb_d;
    logic [DCW-1:0]       deb_cnt_q, deb_cnt_d;
    logic                 press_q, press_d;
    mode_e                mode_q, mode_d;
    logic [SCW-1:0]       step_q, step_d;
    logic [LED_WIDTH-1:0] pat_q, pat_d;
    logic                 led_en_q, led_en_d;
    logic                 init_q;
    logic                 run_c;
    logic                 tick_c;

`ifdef LED_FLOW_PAUSE_EN
    assign run_c = ~pause;
`else
    assign run_c = 1'b1;
`endif

    assign tick_c = (mode_q != MODE_OFF) && run_c && (step_q == SCW'(STEP_CNT - 1));

    // Debounce: accept a new level only after it differed for DEBOUNCE_CNT consecutive cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DCW'(DEBOUNCE_CNT - 1)) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DCW'(1);
            end
        end
        press_d = deb_q & ~deb_d;
    end

    // Mode sequencing, step timing and pattern generation; a press overrides a coincident tick.
    always_comb begin
        mode_d   = mode_q;
        step_d   = step_q;
        pat_d    = pat_q;
        led_en_d = 1'b0;
        if (init_q) begin
            led_en_d = 1'b1;
        end
        if (press_q) begin
            step_d   = '0;
            led_en_d = 1'b1;
            case (mode_q)
                MODE_OFF: begin
                    mode_d = MODE_LEFT;
                    pat_d  = LED_WIDTH'(1);
                end
                MODE_LEFT: begin
                    mode_d = MODE_RIGHT;
                    pat_d  = LED_WIDTH'(1) << (LED_WIDTH - 1);
                end
                MODE_RIGHT: begin
                    mode_d = MODE_BLINK;
                    pat_d  = '1;
                end
                default: begin
                    mode_d = MODE_OFF;
                    pat_d  = '0;
                end
            endcase
        end else if (tick_c) begin
            step_d   = '0;
            led_en_d = 1'b1;
            case (mode_q)
                MODE_LEFT:  pat_d = {pat_q[LED_WIDTH-2:0], pat_q[LED_WIDTH-1]};
                MODE_RIGHT: pat_d = {pat_q[0], pat_q[LED_WIDTH-1:1]};
                default:    pat_d = ~pat_q;
            endcase
        end else if ((mode_q != MODE_OFF) && run_c) begin
            step_d = step_q + SCW'(1);
        end
    end

    // State registers with synchronous reset; init_q forces the post-reset clearing strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
            mode_q    <= MODE_OFF;
            step_q    <= '0;
            pat_q     <= '0;
            led_en_q  <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            sync1_q   <= key_in;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
            mode_q    <= mode_d;
            step_q    <= step_d;
            pat_q     <= pat_d;
            led_en_q  <= led_en_d;
            init_q    <= 1'b0;
        end
    end

    assign led_en    = led_en_q;
    assign led_value = pat_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: directed plus randomized checks of led_flow_ctrl against a behavioural model.
// Build with LED_FLOW_PAUSE_EN defined to exercise the pause input as well.
module tb_led_flow_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;
    localparam int unsigned SC = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_in = 1'b1;
    logic         pause = 1'b0;
    logic         led_en;
    logic [W-1:0] led_value;

    always #5 clk = ~clk;

    led_flow_ctrl #(
        .LED_WIDTH   (W),
        .DEBOUNCE_CNT(DC),
        .STEP_CNT    (SC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
`ifdef LED_FLOW_PAUSE_EN
        .pause    (pause),
`endif
        .led_en   (led_en),
        .led_value(led_value)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    string tag = "init";

    // Behavioural model state: key history, debounce run length, mode, step progress.
    int h1 = 1, h2 = 1, deb = 1, run = 0;
    int mode = 0, pend = 0, post = 1, phase = 0, steps = 0;
    logic         exp_en  = 1'b0;
    logic [W-1:0] exp_val = '0;

    // Pattern shown after `s` completed steps within mode `m`.
    function automatic logic [W-1:0] pat(input int m, input int s);
        logic [W-1:0] one;
        logic [W-1:0] top;
        one = 1;
        top = one << (W - 1);
        case (m)
            1:       return one << (s % W);
            2:       return top >> (s % W);
            3:       return ((s % 2) == 0) ? {W{1'b1}} : {W{1'b0}};
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        int lvl;
        if (rst) begin
            h1 = 1; h2 = 1; deb = 1; run = 0;
            mode = 0; pend = 0; post = 1; phase = 0; steps = 0;
            exp_en = 1'b0; exp_val = '0;
            return;
        end
        exp_en = 1'b0;
        if (post != 0) begin
            exp_en = 1'b1; exp_val = '0; post = 0;
        end
        if (pend != 0) begin
            mode = (mode + 1) % 4; steps = 0; phase = 0;
            exp_en = 1'b1; exp_val = pat(mode, 0);
        end else if (mode != 0 && pause == 1'b0) begin
            phase++;
            if (phase == int'(SC)) begin
                phase = 0; steps++;
                exp_en = 1'b1; exp_val = pat(mode, steps);
            end
        end
        lvl = h2; h2 = h1; h1 = int'(key_in);
        pend = 0;
        if (lvl != deb) begin
            run++;
            if (run == int'(DC)) begin
                pend = (deb == 1) ? 1 : 0;
                deb = lvl; run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        total++;
        assert ({led_en, led_value} === {exp_en, exp_val})
        else begin
            bad++;
            $error("FAIL %s cyc=%0d got en=%b val=%02h want en=%b val=%02h",
                   tag, cyc, led_en, led_value, exp_en, exp_val);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int lo, input int hi);
        key_in = 1'b0;
        ticks(lo);
        key_in = 1'b1;
        ticks(hi);
    endtask

    initial begin
        tag = "reset";
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
        tag = "post_reset_idle";
        ticks(100);

        tag = "glitch";
        press(3, 12);
        tag = "to_left";
        press(20, 60);

        tag = "to_right";
        press(12, 25);
        tag = "to_blink";
        press(12, 25);
        tag = "to_off";
        press(12, 50);

        tag = "align_left";
        press(12, 13);
        for (int i = 0; i < 10 && phase != 3; i++) tick();
        tag = "press_on_tick";
        press(12, 30);

        tag = "blink_reset";
        press(12, 7);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        ticks(10);
        tag = "after_reset_press";
        press(12, 22);

`ifdef LED_FLOW_PAUSE_EN
        tag = "pause_hold";
        ticks(2);
        pause = 1'b1;
        ticks(12);
        pause = 1'b0;
        tag = "pause_resume";
        ticks(20);
        tag = "press_in_pause";
        pause = 1'b1;
        press(12, 15);
        pause = 1'b0;
        ticks(20);
`endif

        tag = "random";
        for (int i = 0; i < 300; i++) begin
            key_in = 1'($urandom_range(0, 1));
`ifdef LED_FLOW_PAUSE_EN
            pause = ($urandom_range(0, 3) == 0);
`endif
            rst = ($urandom_range(0, 49) == 0);
            if (rst) begin
                ticks(1);
                rst = 1'b0;
            end
            ticks(int'($urandom_range(1, 12)));
        end
        rst = 1'b0;
        pause = 1'b0;
        key_in = 1'b1;
        tag = "drain";
        ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
